// File: rtl/gray_counter_registered_if.sv
// Bundle of the counter's control inputs and registered outputs.
// The master drives the qualifiers and load value; the slave is the counter itself.
interface gray_counter_registered_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             step_up;
    logic             step_down;
    logic [WIDTH-1:0] binary_count;
    logic [WIDTH-1:0] gray_count;
    logic             wrap;

    modport master (
        output clear, load_valid, load_value, step_up, step_down,
        input  binary_count, gray_count, wrap
    );

    modport slave (
        input  clear, load_valid, load_value, step_up, step_down,
        output binary_count, gray_count, wrap
    );
endinterface

// File: rtl/gray_counter_registered.sv
// Up/down binary counter with a registered Gray image and a registered wrap pulse.
// The Gray register is loaded from the next binary value, so both outputs always
// describe the same count and the Gray output is glitch-free.
module gray_counter_registered #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] INITIAL = '0
) (
    input  logic                          clk,
    input  logic                          aresetn,
    gray_counter_registered_if.slave      bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Reflected binary code of a binary value.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Next binary value and wrap detection; clear beats load beats a single step.
    always_comb begin
        w_next = r_bin;
        w_wrap = 1'b0;
        if (bus.clear) begin
            w_next = INITIAL;
        end else if (bus.load_valid) begin
            w_next = bus.load_value;
        end else if (bus.step_up && !bus.step_down) begin
            w_next = r_bin + ONE;
            w_wrap = (r_bin == ALL_ONES);
        end else if (bus.step_down && !bus.step_up) begin
            w_next = r_bin - ONE;
            w_wrap = (r_bin == '0);
        end
    end

    // Count, Gray image and wrap pulse all update on the same edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_bin  <= INITIAL;
            r_gray <= to_gray(INITIAL);
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next;
            r_gray <= to_gray(w_next);
            r_wrap <= w_wrap;
        end
    end

    assign bus.binary_count = r_bin;
    assign bus.gray_count   = r_gray;
    assign bus.wrap         = r_wrap;
endmodule

// File: tb/tb_gray_counter_registered.sv
// Self-checking bench for gray_counter_registered (WIDTH=4, INITIAL=5).
module tb_gray_counter_registered;
    localparam int W    = 4;
    localparam int INIT = 5;
    localparam int MOD  = 1 << W;

    logic clk;
    logic aresetn;

    gray_counter_registered_if #(.WIDTH(W)) bus ();

    gray_counter_registered #(.WIDTH(W), .INITIAL(4'(INIT))) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers, modular arithmetic.
    int m_cnt  = INIT;
    int m_wrap = 0;

    typedef struct {
        string    name;
        bit       clr;
        bit       ld;
        int       lv;
        bit       up;
        bit       dn;
        int       exp_bin;
        bit [3:0] exp_gray;
        bit       exp_wrap;
    } vec_t;

    vec_t vecs[12];

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // Gray decode: binary = XOR of all right shifts of the Gray word.
    function automatic int gray_decode(input int g);
        int b = 0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b % MOD;
    endfunction

    task automatic model_edge(input bit clr, input bit ld, input int lv, input bit up, input bit dn);
        if (clr) begin
            m_cnt = INIT; m_wrap = 0;
        end else if (ld) begin
            m_cnt = lv % MOD; m_wrap = 0;
        end else if (up && !dn) begin
            m_wrap = (m_cnt == MOD - 1);
            m_cnt  = (m_cnt + 1) % MOD;
        end else if (dn && !up) begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MOD - 1) % MOD;
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic check(input string name, input int eb, input int eg, input int ew);
        total++;
        if (int'(bus.binary_count) != eb || int'(bus.gray_count) != eg || int'(bus.wrap) != ew) begin
            bad++;
            $display("FAIL %s: got bin=%0d gray=%b wrap=%0d, want bin=%0d gray=%b wrap=%0d",
                     name, bus.binary_count, bus.gray_count, bus.wrap, eb, 4'(eg), ew);
        end
    endtask

    task automatic check_onebit(input string name, input logic [W-1:0] prev);
        total++;
        if ($countones(prev ^ bus.gray_count) != 1) begin
            bad++;
            $display("FAIL %s: gray %b -> %b changes %0d bits, want 1",
                     name, prev, bus.gray_count, $countones(prev ^ bus.gray_count));
        end
    endtask

    // Apply inputs just after a rising edge, clock one edge, compare against the model.
    task automatic drive_edge(input bit clr, input bit ld, input int lv, input bit up, input bit dn);
        bus.clear      = clr;
        bus.load_valid = ld;
        bus.load_value = 4'(lv);
        bus.step_up    = up;
        bus.step_down  = dn;
        model_edge(clr, ld, lv, up, dn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear = 0; bus.load_valid = 0; bus.load_value = '0;
        bus.step_up = 0; bus.step_down = 0;
    endtask

    initial begin
        logic [W-1:0] prev_g;
        bit up, dn, clr, ld;
        int lv, r;

        vecs[0]  = '{"prio_clear",     1, 1,  9, 1, 0,  5, 4'b0111, 0};
        vecs[1]  = '{"prio_load",      0, 1,  9, 1, 0,  9, 4'b1101, 0};
        vecs[2]  = '{"load15",         0, 1, 15, 0, 0, 15, 4'b1000, 0};
        vecs[3]  = '{"both_at15",      1'b0, 0, 0, 1, 1, 15, 4'b1000, 0};
        vecs[4]  = '{"load15to0",      0, 1,  0, 0, 0,  0, 4'b0000, 0};
        vecs[5]  = '{"down_wrap",      0, 0,  0, 0, 1, 15, 4'b1000, 1};
        vecs[6]  = '{"down_after",     0, 0,  0, 0, 1, 14, 4'b1001, 0};
        vecs[7]  = '{"up_to15",        0, 0,  0, 1, 0, 15, 4'b1000, 0};
        vecs[8]  = '{"up_wrap",        0, 0,  0, 1, 0,  0, 4'b0000, 1};
        vecs[9]  = '{"hold",           0, 0,  0, 0, 0,  0, 4'b0000, 0};
        vecs[10] = '{"both_at0",       0, 0,  0, 1, 1,  0, 4'b0000, 0};
        vecs[11] = '{"clear",          1, 0,  0, 0, 0,  5, 4'b0111, 0};

        idle_inputs();
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", INIT, 4'b0111, 0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_hold", INIT, 4'b0111, 0);

        // Table of directed vectors.
        for (int i = 0; i < 12; i++) begin
            drive_edge(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].up, vecs[i].dn);
            check(vecs[i].name, vecs[i].exp_bin, vecs[i].exp_gray, vecs[i].exp_wrap);
            check({vecs[i].name, "_model"}, m_cnt, gray_of(m_cnt), m_wrap);
        end

        // Full up period from 0 with step_up held for 20 cycles.
        drive_edge(0, 1, 0, 0, 0);
        check("period_load0", 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            prev_g = bus.gray_count;
            drive_edge(0, 0, 0, 1, 0);
            check($sformatf("period_%0d", i), i % MOD, gray_of(i % MOD), (i % MOD) == 0);
            check_onebit($sformatf("period_1bit_%0d", i), prev_g);
        end

        // Asynchronous reset in the middle of a cycle while wrap is high.
        drive_edge(0, 1, 15, 0, 0);
        drive_edge(0, 0, 0, 1, 0);
        check("pre_async_wrap", 0, 0, 1);
        bus.step_up = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset", INIT, 4'b0111, 0);
        m_cnt = INIT; m_wrap = 0;
        @(negedge clk);
        idle_inputs();
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("after_async", INIT, 4'b0111, 0);

        // Randomized traffic against the model, with a Gray round-trip decode each cycle.
        for (int i = 0; i < 200; i++) begin
            r   = $urandom_range(0, 15);
            clr = (r == 0);
            ld  = (r == 1);
            lv  = $urandom_range(0, MOD - 1);
            up  = $urandom_range(0, 1);
            dn  = $urandom_range(0, 1);
            prev_g = bus.gray_count;
            drive_edge(clr, ld, lv, up, dn);
            check($sformatf("rand_%0d", i), m_cnt, gray_of(m_cnt), m_wrap);
            total++;
            if (gray_decode(int'(bus.gray_count)) != int'(bus.binary_count)) begin
                bad++;
                $display("FAIL rand_decode_%0d: decoded=%0d binary=%0d", i,
                         gray_decode(int'(bus.gray_count)), bus.binary_count);
            end
            if (!clr && !ld && (up != dn))
                check_onebit($sformatf("rand_1bit_%0d", i), prev_g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
